// File: rtl/lsu_pkg.sv
// Shared LSU constants: bus widths, size codes, FSM encodings and the alignment helper.
// The optional misalignment trap is enabled by defining LSU_MISALIGN_TRAP_EN.
`ifndef DataBus
`define DataBus 31:0
`endif
`ifndef DataAddrBus
`define DataAddrBus 31:0
`endif

package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_STORE  = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        misaligned = ((size == SZ_HALF) && lsb[0]) || ((size == SZ_WORD) && (lsb != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data extraction: byte/half taken from the MSB end of the RAM word (big-endian),
// zero- or sign-extended; words pass through unchanged.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [`DataBus] rdata,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [`DataBus] ext
);

    logic fill;

    always_comb begin
        fill = ~is_unsigned & rdata[31];
        ext  = rdata;
        case (size)
            SZ_BYTE: ext = {{24{fill}}, rdata[31:24]};
            SZ_HALF: ext = {{16{fill}}, rdata[31:16]};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, sub-word stores via read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses with resp_err.
`ifndef DataBus
`define DataBus 31:0
`endif
`ifndef DataAddrBus
`define DataAddrBus 31:0
`endif

module lsu
    import lsu_pkg::*;
#(
    parameter bit RESP_ERR_ON_RSVD = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [`DataAddrBus] req_addr,
    input  logic [`DataBus]     req_wdata,
    output logic                resp_valid,
    output logic [`DataBus]     resp_rdata,
    output logic                resp_err,
    output logic                ram_we,
    output logic [`DataAddrBus] ram_waddr,
    output logic [`DataBus]     ram_wdata,
    output logic                ram_re,
    output logic [`DataAddrBus] ram_raddr,
    input  logic [`DataBus]     ram_rdata
);

    logic [2:0]          state;
    logic [`DataAddrBus] addr_q;
    logic [`DataBus]     wdata_q;
    logic [`DataBus]     merge_q;
    logic [`DataBus]     rdata_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic                err_q;

    logic                hs;
    logic [1:0]          eff_size;
    logic                rsvd_err;
    logic                align_err;
    logic [`DataBus]     ext_data;
    logic [`DataBus]     merged;

    assign req_ready = (state == S_IDLE) && !rst;
    assign hs        = req_valid && req_ready;

    // Reserved size either errors out or degrades to a plain word access.
    always_comb begin
        eff_size = req_size;
        rsvd_err = 1'b0;
        if (req_size == SZ_RSVD) begin
            if (RESP_ERR_ON_RSVD) rsvd_err = 1'b1;
            else                  eff_size = SZ_WORD;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign align_err = misaligned(eff_size, req_addr[1:0]);
`else
    assign align_err = 1'b0;
`endif

    always_comb begin
        merged = wdata_q;
        case (size_q)
            SZ_BYTE: merged = {wdata_q[7:0],  merge_q[23:0]};
            SZ_HALF: merged = {wdata_q[15:0], merge_q[15:0]};
            default: merged = wdata_q;
        endcase
    end

    lsu_extend u_extend (
        .rdata       (ram_rdata),
        .size        (size_q),
        .is_unsigned (uns_q),
        .ext         (ext_data)
    );

    assign ram_re     = !rst && ((state == S_LOAD) || (state == S_RMW_RD));
    assign ram_we     = !rst && ((state == S_STORE) || (state == S_RMW_WR));
    assign ram_raddr  = addr_q;
    assign ram_waddr  = addr_q;
    assign ram_wdata  = merged;
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        size_q  <= eff_size;
                        uns_q   <= req_unsigned;
                        rdata_q <= '0;
                        err_q   <= rsvd_err | align_err;
                        if (rsvd_err | align_err)  state <= S_RESP;
                        else if (!req_we)          state <= S_LOAD;
                        else if (eff_size == SZ_WORD) state <= S_STORE;
                        else                       state <= S_RMW_RD;
                    end
                end
                S_LOAD: begin
                    rdata_q <= ext_data;
                    state   <= S_RESP;
                end
                S_STORE:  state <= S_RESP;
                S_RMW_RD: begin
                    merge_q <= ram_rdata;
                    state   <= S_RMW_WR;
                end
                S_RMW_WR: state <= S_RESP;
                S_RESP:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-addressed big-endian RAM plus a reference byte image.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_we;
    logic [31:0] ram_waddr;
    logic [31:0] ram_wdata;
    logic        ram_re;
    logic [31:0] ram_raddr;
    logic [31:0] ram_rdata;

    logic [7:0] ram     [256];
    logic [7:0] ref_mem [256];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    lsu #(.RESP_ERR_ON_RSVD(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_we       (ram_we),
        .ram_waddr    (ram_waddr),
        .ram_wdata    (ram_wdata),
        .ram_re       (ram_re),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata)
    );

    // Combinational big-endian read: MSB byte at the lowest address.
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        a0 = ram_raddr[7:0];
        a1 = a0 + 8'd1;
        a2 = a0 + 8'd2;
        a3 = a0 + 8'd3;
        ram_rdata = {ram[a0], ram[a1], ram[a2], ram[a3]};
    end

    always @(posedge clk) begin
        if (ram_we) begin
            logic [7:0] w0;
            w0 = ram_waddr[7:0];
            ram[w0]        <= ram_wdata[31:24];
            ram[w0 + 8'd1] <= ram_wdata[23:16];
            ram[w0 + 8'd2] <= ram_wdata[15:8];
            ram[w0 + 8'd3] <= ram_wdata[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b11) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if (addr % nbytes(size) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr);
        int n = nbytes(size);
        longint val = 0;
        logic [7:0] a;
        for (int k = 0; k < n; k++) begin
            a   = addr[7:0] + 8'(k);
            val = val * 256 + longint'(ref_mem[a]);
        end
        if (!uns && n < 4 && val >= (longint'(1) << (8 * n - 1)))
            val = val - (longint'(1) << (8 * n));
        return val[31:0];
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
        int n = nbytes(size);
        logic [7:0] a;
        for (int k = 0; k < n; k++) begin
            a = addr[7:0] + 8'(k);
            ref_mem[a] = 8'((wdata >> (8 * (n - 1 - k))) & 32'hFF);
        end
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] addr);
        logic [7:0] a = addr[7:0];
        return {ram[a], ram[a + 8'd1], ram[a + 8'd2], ram[a + 8'd3]};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [7:0] a = addr[7:0];
        return {ref_mem[a], ref_mem[a + 8'd1], ref_mem[a + 8'd2], ref_mem[a + 8'd3]};
    endfunction

    task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] got_rdata, output logic got_err);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat, exp_re, exp_we;
        int          lat, re_cnt, we_cnt, both_cnt;
        logic [31:0] seen_raddr, seen_waddr;
        logic        ready_in_resp;

        exp_err = model_err(size, addr);
        exp_rd  = (!we && !exp_err) ? model_load(size, uns, addr) : 32'h0;
        if (exp_err)                      begin exp_lat = 1; exp_re = 0; exp_we = 0; end
        else if (!we)                     begin exp_lat = 2; exp_re = 1; exp_we = 0; end
        else if (nbytes(size) == 4)       begin exp_lat = 2; exp_re = 0; exp_we = 1; end
        else                              begin exp_lat = 3; exp_re = 1; exp_we = 1; end

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        check("ready_idle", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;

        lat = 0; re_cnt = 0; we_cnt = 0; both_cnt = 0;
        seen_raddr = addr; seen_waddr = addr; ready_in_resp = 1'b1;
        got_rdata = 32'hX; got_err = 1'bX;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ram_re) begin re_cnt++; seen_raddr = ram_raddr; end
            if (ram_we) begin we_cnt++; seen_waddr = ram_waddr; end
            if (ram_re && ram_we) both_cnt++;
            if (resp_valid) begin
                lat = c; got_rdata = resp_rdata; got_err = resp_err;
                ready_in_resp = req_ready;
                req_valid = 1'b1;  // must be ignored while responding
                break;
            end
            req_valid = 1'($urandom_range(0, 1));
            req_we = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
        end

        check("latency", lat, exp_lat);
        check("resp_err", {31'h0, got_err}, {31'h0, exp_err});
        check("resp_rdata", got_rdata, exp_rd);
        check("re_cycles", re_cnt, exp_re);
        check("we_cycles", we_cnt, exp_we);
        check("re_we_overlap", both_cnt, 0);
        check("raddr", seen_raddr, addr);
        check("waddr", seen_waddr, addr);
        check("ready_in_resp", {31'h0, ready_in_resp}, 32'h0);

        @(negedge clk);
        check("resp_one_cycle", {31'h0, resp_valid}, 32'h0);
        check("ready_after", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b0;

        if (we && !exp_err) model_store(size, addr, wdata);
        check("ram_word", ram_word(addr), ref_word(addr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        gap_resp;
        logic [7:0]  b;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            ram[i] = b; ref_mem[i] = b;
        end
        ram[8'h80] = 8'h81; ram[8'h81] = 8'h23; ram[8'h82] = 8'h45; ram[8'h83] = 8'h67;
        ref_mem[8'h80] = 8'h81; ref_mem[8'h81] = 8'h23; ref_mem[8'h82] = 8'h45; ref_mem[8'h83] = 8'h67;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_ram_we_re", {30'h0, ram_we, ram_re}, 32'h0);
        rst = 1'b0;

        do_op(1'b0, 2'b00, 1'b0, 32'h80, 32'h0, rd, er);
        check("lb_80", rd, 32'hFFFF_FF81);
        do_op(1'b0, 2'b01, 1'b1, 32'h80, 32'h0, rd, er);
        check("lhu_80", rd, 32'h0000_8123);
        do_op(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, rd, er);
        check("lw_80", rd, 32'h8123_4567);
        do_op(1'b1, 2'b00, 1'b0, 32'h80, 32'h0000_00AA, rd, er);
        check("sb_80_err", {31'h0, er}, 32'h0);
        do_op(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, rd, er);
        check("lw_80_after_sb", rd, 32'hAA23_4567);
        do_op(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, rd, er);
        check("sw_40_err", {31'h0, er}, 32'h0);
        check("sw_40_mem", ram_word(32'h40), 32'hDEAD_BEEF);
        do_op(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, rd, er);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_42_err", {31'h0, er}, 32'h1);
`else
        check("lw_42_data", rd[31:16], 32'h0000_BEEF);
`endif
        do_op(1'b0, 2'b11, 1'b0, 32'h80, 32'h0, rd, er);
        check("rsvd_err", {31'h0, er}, 32'h1);

        // Reset landing in the RMW write cycle must suppress the write and the response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmw_rd_re", {31'h0, ram_re}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("rst_in_rmw_we", {31'h0, ram_we}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        gap_resp = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid) gap_resp = 1'b1;
        end
        check("rst_no_resp", {31'h0, gap_resp}, 32'h0);
        check("rst_ready_after", {31'h0, req_ready}, 32'h1);
        check("rst_mem_intact", ram_word(32'h10), ref_word(32'h10));

        for (int i = 0; i < 150; i++) begin
            do_op(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 251)),
                  $urandom, rd, er);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
